// File: rtl/led_pattern_gen.sv
//
// led_pattern_gen
//   Drives a bank of NB_LEDS LEDs with a selectable animated pattern. A
//   prescaler turns the clock into a pattern-advance tick whose period is
//   BASE_PERIOD*(i_speed+1) clocks. On every tick the pattern advances
//   according to the selected mode. The raw pattern is exported on o_led and
//   a colour-gated copy of it goes to each RGB channel.
//
// Ports
//   clock      sole clock, all state updates on its rising edge
//   i_reset    synchronous, active-high reset
//   i_enable   1 = run, 0 = freeze prescaler and pattern
//   i_speed    period select, period = BASE_PERIOD*(i_speed+1)
//   i_mode     00 rotate left, 01 rotate right, 10 bounce, 11 blink
//   i_color    channel enables, bit2 = R, bit1 = G, bit0 = B
//   i_bright   (LED_PWM_DIM_EN only) brightness, duty = (i_bright+1)/4
//   o_led      raw pattern
//   o_led_r/g/b  colour-gated (and optionally dimmed) pattern
//   o_tick     one-cycle pulse in the cycle the pattern advances
//
// Configuration
//   LED_PWM_DIM_EN  when defined, adds i_bright and a free-running 4-bit pwm
//                   counter that dims the colour outputs (never o_led).
//
module led_pattern_gen #(
  parameter int NB_LEDS     = 4,
  parameter int NB_COUNTER  = 32,
  parameter int NB_SPEED    = 3,
  parameter int BASE_PERIOD = 2**24
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_SPEED-1:0] i_speed,
  input  logic [1:0]          i_mode,
  input  logic [2:0]          i_color,
`ifdef LED_PWM_DIM_EN
  input  logic [1:0]          i_bright,
`endif
  output logic [NB_LEDS-1:0]  o_led,
  output logic [NB_LEDS-1:0]  o_led_r,
  output logic [NB_LEDS-1:0]  o_led_g,
  output logic [NB_LEDS-1:0]  o_led_b,
  output logic                o_tick
);

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [NB_LEDS-1:0]    PAT_ONE = NB_LEDS'(1);
  localparam logic [NB_COUNTER-1:0] CNT_ONE = NB_COUNTER'(1);

  logic [NB_COUNTER-1:0] count, count_nxt;
  logic [NB_COUNTER-1:0] period, period_m1;
  logic [NB_LEDS-1:0]    pat, pat_nxt, init_pat, adv_pat;
  dir_e                  dir, dir_nxt, adv_dir;
  mode_e                 mode_ref;
  logic                  mode_changed;
  logic                  tick;
  logic                  pwm_on;

  // Tick period for the current speed setting. Everything is kept at the
  // prescaler width; legal parameters guarantee the product fits.
  always_comb begin
    period    = NB_COUNTER'(BASE_PERIOD) * (NB_COUNTER'(i_speed) + CNT_ONE);
    period_m1 = period - CNT_ONE;
  end

  // A mode change is only acted on while running, so a frozen generator keeps
  // all of its state. The change pre-empts any tick due in the same cycle.
  // The >= compare makes a speed decrease below the current count tick at
  // once instead of letting the prescaler run past the new period.
  always_comb begin
    mode_changed = i_enable && (i_mode != mode_ref);
    tick         = i_enable && !i_reset && !mode_changed && (count >= period_m1);
    init_pat     = (i_mode == MODE_BLINK) ? '0 : PAT_ONE;
  end

  // Pattern that the current one turns into on a tick. In bounce mode the
  // direction flips on the very tick that lands on an end LED, so that end
  // stays lit for exactly one period before the walk reverses.
  always_comb begin
    adv_pat = pat;
    adv_dir = dir;
    case (mode_ref)
      MODE_ROT_L: adv_pat = {pat[NB_LEDS-2:0], pat[NB_LEDS-1]};
      MODE_ROT_R: adv_pat = {pat[0], pat[NB_LEDS-1:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          adv_pat = pat << 1;
          if (adv_pat[NB_LEDS-1]) adv_dir = DIR_DOWN;
        end else begin
          adv_pat = pat >> 1;
          if (adv_pat[0]) adv_dir = DIR_UP;
        end
      end
      MODE_BLINK: adv_pat = (pat == '0) ? '1 : '0;
      default: adv_pat = pat;
    endcase
  end

  // Next-state selection: mode change restarts the pattern, a tick advances
  // it, otherwise the prescaler counts while enabled and holds when frozen.
  always_comb begin
    count_nxt = count;
    pat_nxt   = pat;
    dir_nxt   = dir;
    if (mode_changed) begin
      count_nxt = '0;
      pat_nxt   = init_pat;
      dir_nxt   = DIR_UP;
    end else if (tick) begin
      count_nxt = '0;
      pat_nxt   = adv_pat;
      dir_nxt   = adv_dir;
    end else if (i_enable) begin
      count_nxt = count + CNT_ONE;
    end
  end

  // State register. Reset also snapshots i_mode so that holding the mode
  // steady across reset release is not mistaken for a change.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      count    <= '0;
      pat      <= init_pat;
      dir      <= DIR_UP;
      mode_ref <= mode_e'(i_mode);
    end else begin
      count <= count_nxt;
      pat   <= pat_nxt;
      dir   <= dir_nxt;
      if (mode_changed) mode_ref <= mode_e'(i_mode);
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm;

  // Free-running dimming counter; the top two bits give four duty slots.
  always_ff @(posedge clock) begin
    if (i_reset) pwm <= '0;
    else         pwm <= pwm + 4'd1;
  end

  assign pwm_on = (pwm[3:2] <= i_bright);
`else
  assign pwm_on = 1'b1;
`endif

  assign o_led   = pat;
  assign o_tick  = tick;
  assign o_led_r = (i_color[2] && pwm_on) ? pat : '0;
  assign o_led_g = (i_color[1] && pwm_on) ? pat : '0;
  assign o_led_b = (i_color[0] && pwm_on) ? pat : '0;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The parameter NB_LEDS SHALL default to 4 and set the LED count per channel; legal values are at least 2.
REQ-002 The parameter NB_COUNTER SHALL default to 32 and set the tick prescaler width.
REQ-003 The parameter NB_SPEED SHALL default to 3 and set the speed-select width.
REQ-004 The parameter BASE_PERIOD SHALL default to 2**24 and set the tick period unit in clocks; legal values are at least 1.
REQ-005 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_enable  input  1  1 = run, 0 = freeze.
REQ-008 i_speed  input  NB_SPEED  period select.
REQ-009 i_mode  input  2  pattern select.
REQ-010 i_color  input  3  channel enables: bit2=R, bit1=G, bit0=B.
REQ-011 o_led  output  NB_LEDS  raw pattern.
REQ-012 o_led_r / o_led_g / o_led_b  output  NB_LEDS each  colour-gated pattern.
REQ-013 o_tick  output  1  one-cycle pulse on each pattern advance.

Function
REQ-014 Period P SHALL be BASE_PERIOD*(i_speed+1) clocks, computed at NB_COUNTER width with no overflow for legal parameters.
REQ-015 Prescaler: while i_enable=1 it SHALL increment each cycle; when count >= P-1, o_tick SHALL pulse for 1 cycle and the count SHALL clear to 0.
REQ-016 Lowering i_speed below the current count SHALL produce a tick on the next enabled cycle (the >= compare); the prescaler SHALL never run past P-1.
REQ-017 Pattern register pat SHALL update the cycle after o_tick; o_led SHALL equal pat.
REQ-018 Mode 00 (ROT_L): rotate toward the MSB; bit NB_LEDS-1 wraps to bit 0.
REQ-019 Mode 01 (ROT_R): rotate toward the LSB; bit 0 wraps to bit NB_LEDS-1.
REQ-020 Mode 10 (BOUNCE): single lit bit with a dir flag; it moves up until bit NB_LEDS-1 and down until bit 0; dir flips on the tick that reaches an end, so the end LED is lit for exactly one period.
REQ-021 Mode 11 (BLINK): on each tick, pat SHALL toggle between all-ones and all-zeros.
REQ-022 On an i_mode change, the next cycle SHALL load pat=1 (all-zeros in BLINK), set dir=up and clear the prescaler; no tick SHALL occur in that cycle.
REQ-023 A simultaneous mode change and tick SHALL resolve to the mode-change action.
REQ-024 i_enable=0 SHALL hold the prescaler, pat and dir, and keep o_tick=0; resuming SHALL continue from the held count.
REQ-025 Each o_led_x SHALL be pat when its i_color bit is 1, else 0, driven combinationally from pat and i_color.

Reset
REQ-026 i_reset=1 at a clock edge SHALL clear the prescaler, set pat=1 (all-zeros if i_mode=11), set dir=up and force o_tick=0, overriding i_enable.
REQ-027 Reset SHALL capture the current i_mode as the reference value for change detection.
REQ-028 Reset asserted mid-period SHALL discard the partial count; the first tick after release SHALL occur P cycles later.

Configuration
REQ-029 With macro LED_PWM_DIM_EN defined, the module SHALL add input i_bright (2 bits) and a free-running 4-bit pwm counter that is also cleared by reset.
REQ-030 With LED_PWM_DIM_EN defined, o_led_r/g/b SHALL additionally be gated by (pwm[3:2] <= i_bright), giving duty (i_bright+1)/4; o_led SHALL never be dimmed.
REQ-031 Without LED_PWM_DIM_EN, i_bright and the pwm counter SHALL be absent and the colour outputs SHALL follow REQ-025 only.

Verification (NB_LEDS=4, BASE_PERIOD=4)
REQ-032 Reset, i_speed=0, mode 00, enable=1 -> o_tick every 4 cycles; o_led 0001,0010,0100,1000,0001.
REQ-033 Mode 10, speed 1 -> tick every 8 cycles; o_led 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-034 Mode 11, i_color=101 -> o_led_r=o_led_b toggle 1111/0000, o_led_g=0000 constant.
REQ-035 Speed 7 with count at 20, then switch to speed 0 -> tick on the next cycle, then every 4 cycles.
REQ-036 Mode 00 -> 01 in the same cycle as a tick -> pat=0001, no tick, next tick 4 cycles later; reset mid-period -> o_tick=0, pat=0001.
REQ-037 LED_PWM_DIM_EN defined, i_bright=01, i_color=111, o_led=1111 -> each colour channel high 8 of every 16 cycles; o_led constant 1111.
